reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DW, default 32: register data width in bits.
REQ-002 Parameter AW, default 5: register address width; depth is 2**AW registers.
REQ-003 Parameter BYPASS, default 1: 1 enables write-to-read forwarding; 0 disables it.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; the clock and reset ports are named clk and rst.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 we  in  1  write enable; commits wd to register wa.
REQ-008 wa  in  AW  write address.
REQ-009 wd  in  DW  write data.
REQ-010 ra1, ra2  in  AW each  read addresses.
REQ-011 rd1, rd2  out  DW each  read data, combinational.
REQ-012 iss  in  1  issue strobe; marks register iss_a as pending a write.
REQ-013 iss_a  in  AW  issue destination address.
REQ-014 busy1, busy2  out  1 each  register ra1 or ra2 has a pending write not yet forwardable.
REQ-015 stall  out  1  busy1 OR busy2.
REQ-016 pend_cnt  out  AW+1  number of registers currently marked pending.
REQ-017 waw_err  out  1  registered one-cycle pulse: issue to an already-pending register.

Function
REQ-018 Register 0 SHALL always read 0, never be marked pending, and ignore writes and issues.
REQ-019 On a rising edge with we=1, rst=0 and wa!=0, the block SHALL store wd in register wa.
REQ-020 rdN SHALL be 0 when raN=0; otherwise wd when BYPASS=1, we=1 and wa==raN; otherwise the stored value of register raN.
REQ-021 Pending bits: on an edge, iss=1 with iss_a!=0 sets pending[iss_a]; we=1 with wa!=0 clears pending[wa].
REQ-022 If iss and we target the same nonzero address in one cycle, the pending bit SHALL end set because the new issue takes priority.
REQ-023 busyN SHALL be pending[raN] AND NOT (BYPASS=1 AND we=1 AND wa==raN AND raN!=0); busyN is 0 when raN=0.
REQ-024 pend_cnt SHALL equal the population count of the pending bits after every edge; it is maintained incrementally as +1, -1 or 0 per cycle and never wraps.
REQ-025 Per cycle, pend_cnt SHALL change by +1 on a set of a clear bit, by -1 on a clear of a set bit, and by 0 on a same-address iss+we with the bit already set.
REQ-026 waw_err SHALL be 1 in the cycle after an edge where iss=1, iss_a!=0 and pending[iss_a]=1, excluding the case where the same edge clears iss_a via we; otherwise waw_err is 0.
REQ-027 Read-before-write: with BYPASS=0, a read of wa in the write cycle SHALL return the old value.
REQ-028 Maximum pend_cnt SHALL be 2**AW-1 because register 0 is excluded.

Reset
REQ-029 While rst=1 at an edge, all registers, all pending bits, pend_cnt and waw_err SHALL become 0.
REQ-030 we and iss SHALL be ignored on any edge where rst=1, including mid-sequence with pending bits set.
REQ-031 rd1, rd2, busy1, busy2 and stall SHALL be 0 in the cycle after reset, apart from same-cycle bypass of a new write.

Verification
REQ-032 Reset, then write 0xDEADBEEF to r9 and read ra1=9 on the next cycle -> rd1=0xDEADBEEF; write r0=0x5 -> rd2(ra2=0)=0.
REQ-033 BYPASS=1: with we=1, wa=17, wd=0x12345678 and ra1=17 in one cycle -> rd1=0x12345678 in that cycle; BYPASS=0 -> rd1 holds the old value.
REQ-034 iss r4, then ra1=4 -> busy1=1, stall=1, pend_cnt=1; next cycle we r4 -> busy1=0 in that cycle (BYPASS=1), then pending cleared and pend_cnt=0.
REQ-035 iss r4 twice without a write -> waw_err=1 for exactly one cycle and pend_cnt stays 1; same-cycle iss r4 and we r4 with r4 pending -> no waw_err, pending remains set and pend_cnt is unchanged.
REQ-036 Issue r1..r31 -> pend_cnt=31; assert rst for one cycle -> pend_cnt=0, all busy outputs 0, all reads 0, and a concurrent we is ignored.
REQ-037 Randomised iss/we/ra traffic against a reference model with the pending set and the array -> outputs match every cycle for AW=3, DW=8 and for the default parameters.

Source files
------------

// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - register file / scoreboard port bundle
interface reg_file_sb_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          iss;
    logic [AW-1:0] iss_a;
    logic          busy1;
    logic          busy2;
    logic          stall;
    logic [AW:0]   pend_cnt;
    logic          waw_err;

    modport master (
        output we, wa, wd, ra1, ra2, iss, iss_a,
        input  rd1, rd2, busy1, busy2, stall, pend_cnt, waw_err
    );

    modport slave (
        input  we, wa, wd, ra1, ra2, iss, iss_a,
        output rd1, rd2, busy1, busy2, stall, pend_cnt, waw_err
    );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with write forwarding and pending-write scoreboard
module reg_file_sb #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_sb_if.slave bus
);
    localparam int DEPTH  = 1 << AW;
    localparam bit BYP_EN = (BYPASS != 0);

    logic [DW-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0] r_pend;
    logic [AW:0]      r_pend_cnt;
    logic             r_waw_err;

    logic w_wr_en;
    logic w_iss_en;
    logic w_same;
    logic w_inc;
    logic w_dec;
    logic w_waw;
    logic w_fwd1;
    logic w_fwd2;

    assign w_wr_en  = bus.we && (bus.wa != '0);
    assign w_iss_en = bus.iss && (bus.iss_a != '0);
    // Same-address issue and write: the new issue wins, so the bit stays set.
    assign w_same   = w_wr_en && w_iss_en && (bus.wa == bus.iss_a);
    assign w_inc    = w_iss_en && !r_pend[bus.iss_a];
    assign w_dec    = w_wr_en && r_pend[bus.wa] && !w_same;
    assign w_waw    = w_iss_en && r_pend[bus.iss_a] && !w_same;

    // w_wr_en already excludes address 0, so a forward never hits register 0.
    assign w_fwd1   = BYP_EN && w_wr_en && (bus.wa == bus.ra1);
    assign w_fwd2   = BYP_EN && w_wr_en && (bus.wa == bus.ra2);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_pend     <= '0;
            r_pend_cnt <= '0;
            r_waw_err  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[bus.wa]  <= bus.wd;
                r_pend[bus.wa] <= 1'b0;
            end
            if (w_iss_en) begin
                r_pend[bus.iss_a] <= 1'b1;
            end
            r_pend_cnt <= r_pend_cnt + {{AW{1'b0}}, w_inc} - {{AW{1'b0}}, w_dec};
            r_waw_err  <= w_waw;
        end
    end

    always_comb begin
        bus.rd1 = '0;
        bus.rd2 = '0;
        if (bus.ra1 != '0) begin
            bus.rd1 = w_fwd1 ? bus.wd : r_mem[bus.ra1];
        end
        if (bus.ra2 != '0) begin
            bus.rd2 = w_fwd2 ? bus.wd : r_mem[bus.ra2];
        end
    end

    // r_pend[0] is never set, so a zero read address reports not busy.
    assign bus.busy1    = r_pend[bus.ra1] && !w_fwd1;
    assign bus.busy2    = r_pend[bus.ra2] && !w_fwd2;
    assign bus.stall    = bus.busy1 || bus.busy2;
    assign bus.pend_cnt = r_pend_cnt;
    assign bus.waw_err  = r_waw_err;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - scoreboard bench for reg_file_sb, default and narrow no-bypass instances
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_sb_if #(.DW(32), .AW(5)) bus_a ();
    reg_file_sb_if #(.DW(8),  .AW(3)) bus_b ();

    reg_file_sb #(.DW(32), .AW(5), .BYPASS(1)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
    reg_file_sb #(.DW(8),  .AW(3), .BYPASS(0)) u_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic        c_rst, c_we, c_iss;
    logic [31:0] c_wa, c_wd, c_iss_a, c_ra1, c_ra2;

    logic [31:0] m_mem [2][32];
    logic [31:0] m_pend [2];
    logic        m_waw [2];

    function automatic int amask(int k);
        return (k == 0) ? 31 : 7;
    endfunction

    function automatic logic [31:0] dmask(int k);
        return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    function automatic logic [63:0] m_rd(int k, logic [31:0] ra);
        int a = int'(ra) & amask(k);
        int w = int'(c_wa) & amask(k);
        if (a == 0) return 64'd0;
        if (k == 0 && c_we && w == a) return 64'(c_wd & dmask(k));
        return 64'(m_mem[k][a]);
    endfunction

    function automatic logic m_busy(int k, logic [31:0] ra);
        int a = int'(ra) & amask(k);
        int w = int'(c_wa) & amask(k);
        if (a == 0) return 1'b0;
        return m_pend[k][a] && !(k == 0 && c_we && w == a);
    endfunction

    function automatic logic [63:0] exp_comb(int k, int sel);
        case (sel)
            0:       return m_rd(k, c_ra1);
            1:       return m_rd(k, c_ra2);
            2:       return 64'(m_busy(k, c_ra1));
            3:       return 64'(m_busy(k, c_ra2));
            default: return 64'(m_busy(k, c_ra1) | m_busy(k, c_ra2));
        endcase
    endfunction

    function automatic logic [63:0] obs(int k, int sel);
        if (k == 0) begin
            case (sel)
                0:       return 64'(bus_a.rd1);
                1:       return 64'(bus_a.rd2);
                2:       return 64'(bus_a.busy1);
                3:       return 64'(bus_a.busy2);
                4:       return 64'(bus_a.stall);
                5:       return 64'(bus_a.pend_cnt);
                default: return 64'(bus_a.waw_err);
            endcase
        end
        case (sel)
            0:       return 64'(bus_b.rd1);
            1:       return 64'(bus_b.rd2);
            2:       return 64'(bus_b.busy1);
            3:       return 64'(bus_b.busy2);
            4:       return 64'(bus_b.stall);
            5:       return 64'(bus_b.pend_cnt);
            default: return 64'(bus_b.waw_err);
        endcase
    endfunction

    function automatic string tag_of(int k, int sel);
        string names[7] = '{"rd1", "rd2", "busy1", "busy2", "stall", "pend_cnt", "waw_err"};
        return {(k == 0) ? "a_" : "b_", names[sel]};
    endfunction

    task automatic chk(input logic [63:0] o);
        exp_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", o);
            return;
        end
        e = q.pop_front();
        n_cmp++;
        assert (o === e.val) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
        end
    endtask

    task automatic expect_now(input string tag, input logic [63:0] e, input logic [63:0] o);
        q.push_back('{tag, e});
        chk(o);
    endtask

    task automatic drive(input logic rst_v, input logic we_v, input logic [31:0] wa_v,
                         input logic [31:0] wd_v, input logic iss_v, input logic [31:0] ia_v,
                         input logic [31:0] ra1_v, input logic [31:0] ra2_v);
        c_rst = rst_v; c_we = we_v; c_wa = wa_v; c_wd = wd_v;
        c_iss = iss_v; c_iss_a = ia_v; c_ra1 = ra1_v; c_ra2 = ra2_v;
        rst         = rst_v;
        bus_a.we    = we_v;      bus_b.we    = we_v;
        bus_a.wa    = wa_v[4:0]; bus_b.wa    = wa_v[2:0];
        bus_a.wd    = wd_v;      bus_b.wd    = wd_v[7:0];
        bus_a.iss   = iss_v;     bus_b.iss   = iss_v;
        bus_a.iss_a = ia_v[4:0]; bus_b.iss_a = ia_v[2:0];
        bus_a.ra1   = ra1_v[4:0]; bus_b.ra1  = ra1_v[2:0];
        bus_a.ra2   = ra2_v[4:0]; bus_b.ra2  = ra2_v[2:0];
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < 5; s++)
                q.push_back('{tag_of(k, s), exp_comb(k, s)});
        #1;
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < 5; s++)
                chk(obs(k, s));
    endtask

    task automatic model_edge(input int k);
        int w  = int'(c_wa) & amask(k);
        int ia = int'(c_iss_a) & amask(k);
        if (c_rst) begin
            for (int i = 0; i < 32; i++) m_mem[k][i] = '0;
            m_pend[k] = '0;
            m_waw[k]  = 1'b0;
        end else begin
            m_waw[k] = c_iss && ia != 0 && m_pend[k][ia] && !(c_we && w == ia);
            if (c_we && w != 0) begin
                m_mem[k][w]  = c_wd & dmask(k);
                m_pend[k][w] = 1'b0;
            end
            if (c_iss && ia != 0) m_pend[k][ia] = 1'b1;
        end
    endtask

    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            model_edge(k);
            q.push_back('{tag_of(k, 5), 64'($countones(m_pend[k]))});
            q.push_back('{tag_of(k, 6), 64'(m_waw[k])});
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk(obs(k, 5));
            chk(obs(k, 6));
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) m_mem[k][i] = '0;
            m_pend[k] = '0;
            m_waw[k]  = 1'b0;
        end
        c_rst = 1'b1; c_we = 1'b0; c_iss = 1'b0;
        c_wa = '0; c_wd = '0; c_iss_a = '0; c_ra1 = '0; c_ra2 = '0;
        bus_a.we = 1'b0; bus_a.wa = '0; bus_a.wd = '0; bus_a.iss = 1'b0;
        bus_a.iss_a = '0; bus_a.ra1 = '0; bus_a.ra2 = '0;
        bus_b.we = 1'b0; bus_b.wa = '0; bus_b.wd = '0; bus_b.iss = 1'b0;
        bus_b.iss_a = '0; bus_b.ra1 = '0; bus_b.ra2 = '0;
        @(posedge clk);
        #1;
        expect_now("rst_pend_cnt", 64'd0, 64'(bus_a.pend_cnt));
        expect_now("rst_waw_err", 64'd0, 64'(bus_a.waw_err));

        drive(0, 1, 9, 32'hDEAD_BEEF, 0, 0, 9, 0);
        expect_now("rst_rd1_before_write", 64'd0, 64'(bus_b.rd1));
        tick();
        drive(0, 1, 0, 32'h5, 0, 0, 9, 0);
        expect_now("r9_readback", 64'hDEAD_BEEF, 64'(bus_a.rd1));
        expect_now("r0_reads_zero", 64'd0, 64'(bus_a.rd2));
        tick();

        drive(0, 1, 17, 32'h1234_5678, 0, 0, 17, 0);
        expect_now("bypass_rd1", 64'h1234_5678, 64'(bus_a.rd1));
        expect_now("nobypass_old_rd1", 64'hEF, 64'(bus_b.rd1));
        tick();

        drive(0, 0, 0, 0, 1, 4, 0, 0);
        tick();
        expect_now("iss4_pend_cnt", 64'd1, 64'(bus_a.pend_cnt));
        drive(0, 0, 0, 0, 0, 0, 4, 0);
        expect_now("iss4_busy1", 64'd1, 64'(bus_a.busy1));
        expect_now("iss4_stall", 64'd1, 64'(bus_a.stall));
        tick();
        drive(0, 1, 4, 32'hAA, 0, 0, 4, 0);
        expect_now("wr4_busy1_fwd", 64'd0, 64'(bus_a.busy1));
        expect_now("wr4_busy1_nofwd", 64'd1, 64'(bus_b.busy1));
        tick();
        expect_now("wr4_pend_cnt", 64'd0, 64'(bus_a.pend_cnt));

        drive(0, 0, 0, 0, 1, 4, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 4, 0, 0);
        tick();
        expect_now("waw_pulse", 64'd1, 64'(bus_a.waw_err));
        expect_now("waw_pend_cnt", 64'd1, 64'(bus_a.pend_cnt));
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        expect_now("waw_one_cycle", 64'd0, 64'(bus_a.waw_err));
        drive(0, 1, 4, 32'hBB, 1, 4, 0, 0);
        tick();
        expect_now("same_iss_we_waw", 64'd0, 64'(bus_a.waw_err));
        expect_now("same_iss_we_cnt", 64'd1, 64'(bus_a.pend_cnt));
        drive(0, 0, 0, 0, 0, 0, 4, 0);
        expect_now("same_iss_we_busy", 64'd1, 64'(bus_a.busy1));

        for (int i = 1; i < 32; i++) begin
            drive(0, 0, 0, 0, 1, 32'(i), 0, 0);
            tick();
        end
        expect_now("full_pend_cnt_a", 64'd31, 64'(bus_a.pend_cnt));
        expect_now("full_pend_cnt_b", 64'd7, 64'(bus_b.pend_cnt));
        drive(1, 1, 9, 32'h1234, 1, 5, 9, 5);
        tick();
        expect_now("mid_rst_pend_cnt", 64'd0, 64'(bus_a.pend_cnt));
        drive(0, 0, 0, 0, 0, 0, 9, 5);
        expect_now("mid_rst_rd1", 64'd0, 64'(bus_a.rd1));
        expect_now("mid_rst_stall", 64'd0, 64'(bus_a.stall));
        tick();

        for (int n = 0; n < 400; n++) begin
            logic [31:0] wa_r;
            logic [31:0] ra1_r;
            wa_r  = $urandom_range(0, 31);
            ra1_r = ($urandom_range(0, 3) == 0) ? wa_r : $urandom_range(0, 31);
            drive(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), wa_r, $urandom,
                  1'($urandom_range(0, 1)), $urandom_range(0, 31), ra1_r, $urandom_range(0, 31));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
